// File: rtl/pc_gen.sv
// Fetch-stage PC generator: picks the next PC from exception, branch, jump or sequential sources,
// and buffers redirects that arrive during a fetch stall so they are applied on release.
module pc_gen #(
    parameter int              PC_W     = 7,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              STEP     = 1,
    parameter logic [PC_W-1:0] EXC_VEC  = 7'h78
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            exc_en,
    input  logic            br_en,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_target,
    output logic [PC_W-1:0] pcf,
    output logic [PC_W-1:0] pc_plus,
    output logic            pcf_valid,
    output logic            redir_taken,
    output logic            redir_pending
);

    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_JMP  = 2'd1,
        PRIO_BR   = 2'd2,
        PRIO_EXC  = 2'd3
    } prio_t;

    localparam logic [PC_W-1:0] STEP_W = PC_W'(STEP);

    prio_t           live_prio;
    logic [PC_W-1:0] live_target;
    logic            take_live;

    prio_t           pend_prio, pend_prio_nxt;
    logic [PC_W-1:0] pend_target, pend_target_nxt;
    logic            pend_valid, pend_valid_nxt;
    logic [PC_W-1:0] pcf_nxt;
    logic            redir_taken_nxt;

    assign pc_plus       = pcf + STEP_W;
    assign redir_pending = pend_valid;

    always_comb begin
        live_prio   = PRIO_NONE;
        live_target = '0;
        if (exc_en) begin
            live_prio   = PRIO_EXC;
            live_target = EXC_VEC;
        end else if (br_en) begin
            live_prio   = PRIO_BR;
            live_target = br_target;
        end else if (jmp_en) begin
            live_prio   = PRIO_JMP;
            live_target = jmp_target;
        end
    end

    // An empty slot has prio NONE, so any live request wins against it; ties go to the newer request.
    assign take_live = (live_prio != PRIO_NONE) && (live_prio >= pend_prio);

    always_comb begin
        pcf_nxt         = pcf;
        redir_taken_nxt = 1'b0;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        pend_prio_nxt   = pend_prio;

        if (stall_f) begin
            if (take_live) begin
                pend_valid_nxt  = 1'b1;
                pend_target_nxt = live_target;
                pend_prio_nxt   = live_prio;
            end
        end else begin
            if (take_live) begin
                pcf_nxt         = live_target;
                redir_taken_nxt = 1'b1;
            end else if (pend_valid) begin
                pcf_nxt         = pend_target;
                redir_taken_nxt = 1'b1;
            end else begin
                pcf_nxt = pc_plus;
            end
            pend_valid_nxt  = 1'b0;
            pend_target_nxt = '0;
            pend_prio_nxt   = PRIO_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf         <= RESET_PC;
            pcf_valid   <= 1'b0;
            redir_taken <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            pend_prio   <= PRIO_NONE;
        end else begin
            pcf         <= pcf_nxt;
            pcf_valid   <= 1'b1;
            redir_taken <= redir_taken_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
            pend_prio   <= pend_prio_nxt;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a default 7-bit word-addressed instance and a
// 32-bit byte-addressed instance, checked against hand-computed PC sequences.
module tb_pc_gen;

    logic clk;

    logic       rst, stall_f, exc_en, br_en, jmp_en;
    logic [6:0] br_target, jmp_target;
    logic [6:0] pcf, pc_plus;
    logic       pcf_valid, redir_taken, redir_pending;

    logic        rst_w, stall_w, exc_w, br_w, jmp_w;
    logic [31:0] br_target_w, jmp_target_w;
    logic [31:0] pcf_w, pc_plus_w;
    logic        pcf_valid_w, redir_taken_w, redir_pending_w;

    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .exc_en(exc_en),
        .br_en(br_en), .br_target(br_target), .jmp_en(jmp_en), .jmp_target(jmp_target),
        .pcf(pcf), .pc_plus(pc_plus), .pcf_valid(pcf_valid),
        .redir_taken(redir_taken), .redir_pending(redir_pending)
    );

    pc_gen #(
        .PC_W(32), .RESET_PC(32'h100), .STEP(4), .EXC_VEC(32'h78)
    ) dut_w (
        .clk(clk), .rst(rst_w), .stall_f(stall_w), .exc_en(exc_w),
        .br_en(br_w), .br_target(br_target_w), .jmp_en(jmp_w), .jmp_target(jmp_target_w),
        .pcf(pcf_w), .pc_plus(pc_plus_w), .pcf_valid(pcf_valid_w),
        .redir_taken(redir_taken_w), .redir_pending(redir_pending_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs to the 7-bit instance and step past the next rising edge.
    task automatic applyStimulus(input logic st, input logic ex, input logic br, input logic [6:0] brt,
                                 input logic jp, input logic [6:0] jpt);
        stall_f    = st;
        exc_en     = ex;
        br_en      = br;
        br_target  = brt;
        jmp_en     = jp;
        jmp_target = jpt;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusWide(input logic st, input logic br, input logic [31:0] brt,
                                     input logic jp, input logic [31:0] jpt);
        stall_w      = st;
        exc_w        = 1'b0;
        br_w         = br;
        br_target_w  = brt;
        jmp_w        = jp;
        jmp_target_w = jpt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall_f = 0; exc_en = 0; br_en = 0; jmp_en = 0; br_target = '0; jmp_target = '0;
        rst_w = 1'b1;
        stall_w = 0; exc_w = 0; br_w = 0; jmp_w = 0; br_target_w = '0; jmp_target_w = '0;

        // Reset held for three cycles, then free run
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pcf", 32'(pcf), 32'h00);
        checkOutput("rst_valid", 32'(pcf_valid), 32'd0);
        checkOutput("rst_pending", 32'(redir_pending), 32'd0);
        checkOutput("rst_taken", 32'(redir_taken), 32'd0);
        checkOutput("rst_pc_plus", 32'(pc_plus), 32'h01);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("run1_pcf", 32'(pcf), 32'h01);
        checkOutput("run1_valid", 32'(pcf_valid), 32'd1);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("run2_pcf", 32'(pcf), 32'h02);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("run3_pcf", 32'(pcf), 32'h03);
        checkOutput("run3_taken", 32'(redir_taken), 32'd0);

        // Unstalled jump to 7E, then sequential wrap through 0
        applyStimulus(0, 0, 0, 7'h00, 1, 7'h7E);
        checkOutput("jmp_pcf", 32'(pcf), 32'h7E);
        checkOutput("jmp_taken", 32'(redir_taken), 32'd1);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("wrap_7f", 32'(pcf), 32'h7F);
        checkOutput("wrap_taken", 32'(redir_taken), 32'd0);
        checkOutput("wrap_pc_plus", 32'(pc_plus), 32'h00);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("wrap_00", 32'(pcf), 32'h00);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("wrap_01", 32'(pcf), 32'h01);

        // All three requests at once: exception wins
        applyStimulus(0, 1, 1, 7'h20, 1, 7'h10);
        checkOutput("simul_pcf", 32'(pcf), 32'h78);
        checkOutput("simul_taken", 32'(redir_taken), 32'd1);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("simul_next", 32'(pcf), 32'h79);
        checkOutput("simul_taken_drop", 32'(redir_taken), 32'd0);

        // Branch beats jump when both are live
        applyStimulus(0, 0, 1, 7'h10, 1, 7'h55);
        checkOutput("br_over_jmp", 32'(pcf), 32'h10);

        // Redirects while stalled: jmp 30, then br 40 replaces it, later jmp 50 does not
        applyStimulus(1, 0, 0, 7'h00, 1, 7'h30);
        checkOutput("stall1_pcf", 32'(pcf), 32'h10);
        checkOutput("stall1_pending", 32'(redir_pending), 32'd1);
        checkOutput("stall1_taken", 32'(redir_taken), 32'd0);
        applyStimulus(1, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("stall2_pcf", 32'(pcf), 32'h10);
        applyStimulus(1, 0, 1, 7'h40, 0, 7'h00);
        checkOutput("stall3_pcf", 32'(pcf), 32'h10);
        applyStimulus(1, 0, 0, 7'h00, 1, 7'h50);
        checkOutput("stall4_pcf", 32'(pcf), 32'h10);
        checkOutput("stall4_pending", 32'(redir_pending), 32'd1);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("release_pcf", 32'(pcf), 32'h40);
        checkOutput("release_taken", 32'(redir_taken), 32'd1);
        checkOutput("release_pending", 32'(redir_pending), 32'd0);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("release_next", 32'(pcf), 32'h41);

        // Release with a lower-priority live jump: pending branch wins
        applyStimulus(1, 0, 1, 7'h40, 0, 7'h00);
        applyStimulus(0, 0, 0, 7'h00, 1, 7'h60);
        checkOutput("rel_jmp_pcf", 32'(pcf), 32'h40);

        // Release with a live exception: exception overrides pending branch
        applyStimulus(1, 0, 1, 7'h40, 0, 7'h00);
        applyStimulus(0, 1, 0, 7'h00, 0, 7'h00);
        checkOutput("rel_exc_pcf", 32'(pcf), 32'h78);
        checkOutput("rel_exc_pending", 32'(redir_pending), 32'd0);

        // Equal-priority newer request replaces the older one; live equal prio at release wins too
        applyStimulus(1, 0, 1, 7'h40, 0, 7'h00);
        applyStimulus(1, 0, 1, 7'h44, 0, 7'h00);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("replace_pcf", 32'(pcf), 32'h44);
        applyStimulus(1, 0, 1, 7'h40, 0, 7'h00);
        applyStimulus(0, 0, 1, 7'h22, 0, 7'h00);
        checkOutput("rel_equal_pcf", 32'(pcf), 32'h22);

        // Asynchronous reset mid-stall discards the pending redirect
        applyStimulus(1, 0, 1, 7'h40, 0, 7'h00);
        checkOutput("pre_rst_pending", 32'(redir_pending), 32'd1);
        stall_f = 1'b1; br_en = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput("async_rst_pcf", 32'(pcf), 32'h00);
        checkOutput("async_rst_pending", 32'(redir_pending), 32'd0);
        checkOutput("async_rst_valid", 32'(pcf_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("post_rst_hold", 32'(pcf), 32'h00);
        checkOutput("post_rst_valid", 32'(pcf_valid), 32'd1);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("post_rst_seq1", 32'(pcf), 32'h01);
        checkOutput("post_rst_taken", 32'(redir_taken), 32'd0);
        applyStimulus(0, 0, 0, 7'h00, 0, 7'h00);
        checkOutput("post_rst_seq2", 32'(pcf), 32'h02);

        // 32-bit byte-addressed instance
        checkOutput("w_rst_pcf", pcf_w, 32'h100);
        checkOutput("w_rst_valid", 32'(pcf_valid_w), 32'd0);
        rst_w = 1'b0;
        applyStimulusWide(0, 0, 32'h0, 0, 32'h0);
        checkOutput("w_seq1", pcf_w, 32'h104);
        checkOutput("w_valid", 32'(pcf_valid_w), 32'd1);
        applyStimulusWide(0, 0, 32'h0, 0, 32'h0);
        checkOutput("w_seq2", pcf_w, 32'h108);
        applyStimulusWide(0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        checkOutput("w_jmp", pcf_w, 32'hFFFF_FFFC);
        applyStimulusWide(0, 0, 32'h0, 0, 32'h0);
        checkOutput("w_wrap", pcf_w, 32'h0);
        applyStimulusWide(1, 1, 32'h2000, 0, 32'h0);
        checkOutput("w_stall_pending", 32'(redir_pending_w), 32'd1);
        rst_w = 1'b1;
        #2;
        checkOutput("w_async_rst_pcf", pcf_w, 32'h100);
        checkOutput("w_async_rst_pending", 32'(redir_pending_w), 32'd0);
        @(posedge clk);
        #1;
        rst_w = 1'b0;
        applyStimulusWide(0, 0, 32'h0, 0, 32'h0);
        checkOutput("w_post_rst_seq", pcf_w, 32'h104);
        checkOutput("w_post_rst_taken", 32'(redir_taken_w), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-stage PC generator for the pipelined CPU; successor to the fixed 7-bit stallable PC register.
- Holds the fetch PC and selects the next PC from four sources in priority order: exception vector, branch target, jump target, sequential increment.
- Redirects that arrive while fetch is stalled are buffered in a one-entry pending slot and applied when the stall releases, so no redirect is lost.

Parameters:
- PC_W, 7, PC width in bits (legal range 4..32).
- RESET_PC, 0, PC value loaded on reset.
- STEP, 1, sequential increment added to the PC (word-addressed = 1, byte-addressed = 4).
- EXC_VEC, 7'h78, exception handler address, PC_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_f  in  1  fetch stall from the hazard unit; 1 = hold PC.
- exc_en  in  1  exception redirect request.
- br_en  in  1  taken-branch redirect request.
- br_target  in  PC_W  branch target.
- jmp_en  in  1  jump redirect request.
- jmp_target  in  PC_W  jump target.
- pcf  out  PC_W  current fetch PC (registered).
- pc_plus  out  PC_W  pcf+STEP (combinational, modulo 2^PC_W).
- pcf_valid  out  1  pcf holds a fetchable address.
- redir_taken  out  1  one-cycle pulse: pcf was loaded from a redirect at the last edge.
- redir_pending  out  1  pending slot occupied.

Behaviour:
- Reset (async, rst=1): pcf=RESET_PC, pcf_valid=0, redir_taken=0, pending slot cleared (redir_pending=0, pend_target=0, pend_prio=0). Reset mid-stall or with a pending redirect discards it.
- pcf_valid rises at the first rising edge after rst deasserts and stays 1 until the next reset.
- Priority encoding of live requests: exc=3, br=2, jmp=1, none=0. Live target: EXC_VEC, br_target or jmp_target. Only the highest-priority live request counts in a cycle.
- Not stalled (stall_f=0), at each edge:
  - live prio > 0 and live prio >= pend_prio: pcf <= live target.
  - else if pending: pcf <= pend_target.
  - else: pcf <= pc_plus.
  - The pending slot always clears. redir_taken <= 1 if pcf was loaded from a live or pending redirect, else 0.
- Stalled (stall_f=1): pcf holds and redir_taken <= 0.
  - If live prio > 0 and live prio >= pend_prio, the slot captures the live target and prio (a newer equal-priority request replaces an older one).
  - Otherwise the slot is unchanged.
- Stall release: on the first unstalled edge the pending target is applied (or is overridden per the rule above). Latency from stall release to the redirected pcf is 1 edge.
- Unstalled redirect latency: request in cycle N gives pcf = target after edge N.
- Wrap-around: pcf = 2^PC_W - STEP with sequential advance wraps to 0 (no overflow flag). Targets are used unmodified (no alignment check).
- redir_pending = pending-slot valid bit, registered.

Test Plan:
- Reset then free run, PC_W=7, STEP=1: rst high 3 cycles, then low → pcf=0, pcf_valid=0 during reset; pcf_valid=1 after first edge; pcf = 1,2,3… on successive edges; redir_taken=0.
- Wrap: run from 7'h7E → pcf sequence 7'h7E, 7'h7F, 7'h00, 7'h01.
- Simultaneous requests unstalled: exc_en=1, br_en=1 (br_target=7'h20), jmp_en=1 in one cycle → next pcf=7'h78, redir_taken=1 for exactly one cycle, then pcf=7'h79.
- Redirect during stall: pcf=7'h10, stall_f=1 for 4 cycles, jmp_en=1 (7'h30) in stall cycle 1, br_en=1 (7'h40) in stall cycle 3 → pcf holds 7'h10 and redir_pending=1 from cycle 2. After release: pcf=7'h40, then 7'h41. Lower-priority later jmp (7'h50) during the same stall does not replace 7'h40.
- Release with live request: pending br 7'h40, stall drops in the same cycle that jmp_en=1 (7'h60) → pcf=7'h40. Same case with exc_en=1 → pcf=7'h78.
- Reset mid-stall with pending redirect: rst pulse → pcf=RESET_PC, redir_pending=0; after release, sequential fetch from 0 with no stale redirect. Repeat with PC_W=32, STEP=4, RESET_PC=32'h100 → pcf = 32'h100, 32'h104, …
